// File: rtl/mult_8x8_ctrl_if.sv
// Control bundle between the sequential 8x8 multiplier controller and the
// parties around it (request source, shared 4x4 datapath, seven-segment
// decoder).
//   start      request to begin a multiply (level sampled)
//   a_sel      operand A nibble select (0 = A[3:0], 1 = A[7:4])
//   b_sel      operand B nibble select (0 = B[3:0], 1 = B[7:4])
//   shift_sel  partial product shift (0 = <<0, 1 = <<4, 2 = <<8)
//   acc_load   accumulator overwrite with shifted product
//   acc_en     accumulator add of shifted product
//   busy       controller is stepping through the partial products
//   done       accumulator holds the final product
//   state_out  state code for the seven-segment decoder
// Modports: master = request/datapath side, slave = controller.
interface mult_8x8_ctrl_if;
  logic       start;
  logic       a_sel;
  logic       b_sel;
  logic [1:0] shift_sel;
  logic       acc_load;
  logic       acc_en;
  logic       busy;
  logic       done;
  logic [2:0] state_out;

  modport master (
    output start,
    input  a_sel, b_sel, shift_sel, acc_load, acc_en, busy, done, state_out
  );

  modport slave (
    input  start,
    output a_sel, b_sel, shift_sel, acc_load, acc_en, busy, done, state_out
  );
endinterface

// File: rtl/mult_8x8_ctrl.sv
// Control FSM for the sequential 8x8 multiplier. Steps the shared 4x4
// multiplier through the four nibble partial products (one per cycle),
// steering the nibble selects, product shift and accumulator load/add, then
// flags completion. Outputs are Moore, decoded from state and cnt only.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    mult_8x8_ctrl_if.slave control bundle (start in, controls out)
// Parameter:
//   HOLD_DONE  1: DONE/done held until the next start; 0: done is a pulse
// Optional feature (macro MULT_CTRL_ERR_EN): a new start seen during
// cnt1..cnt3 of CALC aborts to an error state shown as "E" (code 3'b111).
module mult_8x8_ctrl #(
  parameter bit HOLD_DONE = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  mult_8x8_ctrl_if.slave bus
);

`ifdef MULT_CTRL_ERR_EN
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;
`endif

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CALC;
          cnt_nxt   = '0;
        end
      end
      CALC: begin
`ifdef MULT_CTRL_ERR_EN
        // At cnt0 start is still the original request being held; only a
        // later start is treated as a conflicting new request.
        if (bus.start && (cnt != 2'd0)) begin
          state_nxt = ERR;
          cnt_nxt   = '0;
        end else
`endif
        if (cnt == 2'd3) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = CALC;
          cnt_nxt   = '0;
        end else if (!HOLD_DONE) begin
          state_nxt = IDLE;
        end
      end
`ifdef MULT_CTRL_ERR_EN
      ERR: begin
        if (!bus.start) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    bus.a_sel     = 1'b0;
    bus.b_sel     = 1'b0;
    bus.shift_sel = 2'd0;
    bus.acc_load  = 1'b0;
    bus.acc_en    = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.state_out = 3'b000;
    case (state)
      CALC: begin
        bus.busy      = 1'b1;
        bus.state_out = 3'b001;
        case (cnt)
          2'd0: begin
            bus.acc_load = 1'b1;
          end
          2'd1: begin
            bus.b_sel     = 1'b1;
            bus.shift_sel = 2'd1;
            bus.acc_en    = 1'b1;
          end
          2'd2: begin
            bus.a_sel     = 1'b1;
            bus.shift_sel = 2'd1;
            bus.acc_en    = 1'b1;
          end
          default: begin
            bus.a_sel     = 1'b1;
            bus.b_sel     = 1'b1;
            bus.shift_sel = 2'd2;
            bus.acc_en    = 1'b1;
          end
        endcase
      end
      DONE: begin
        bus.done      = 1'b1;
        bus.state_out = 3'b010;
      end
`ifdef MULT_CTRL_ERR_EN
      ERR: begin
        bus.state_out = 3'b111;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mult_8x8_ctrl.sv
// Bench for mult_8x8_ctrl: two instances (HOLD_DONE=1 and HOLD_DONE=0) share
// one stimulus stream. Each drives a small 4x4 datapath model; expected
// products (plain A*B) and done cycles are queued at issue time and popped by
// per-instance monitors on the first cycle of done.
module tb_mult_8x8_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a_op, b_op;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    int          cyc;
    int unsigned prod;
  } exp_t;

  exp_t q_h[$];
  exp_t q_p[$];
  exp_t e_h, e_p;

  localparam logic [10:0] O_IDLE = 11'b0_0_00_0_0_0_0_000;
  localparam logic [10:0] O_C0   = 11'b0_0_00_1_0_1_0_001;
  localparam logic [10:0] O_C1   = 11'b0_1_01_0_1_1_0_001;
  localparam logic [10:0] O_C2   = 11'b1_0_01_0_1_1_0_001;
  localparam logic [10:0] O_C3   = 11'b1_1_10_0_1_1_0_001;
  localparam logic [10:0] O_DONE = 11'b0_0_00_0_0_0_1_010;
  localparam logic [10:0] O_ERR  = 11'b0_0_00_0_0_0_0_111;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_8x8_ctrl_if bus_h ();
  mult_8x8_ctrl_if bus_p ();
  assign bus_h.start = start;
  assign bus_p.start = start;

  mult_8x8_ctrl #(.HOLD_DONE(1'b1)) dut_h (.clk(clk), .reset(reset), .bus(bus_h));
  mult_8x8_ctrl #(.HOLD_DONE(1'b0)) dut_p (.clk(clk), .reset(reset), .bus(bus_p));

  logic [10:0] o_h, o_p;
  assign o_h = {bus_h.a_sel, bus_h.b_sel, bus_h.shift_sel, bus_h.acc_load,
                bus_h.acc_en, bus_h.busy, bus_h.done, bus_h.state_out};
  assign o_p = {bus_p.a_sel, bus_p.b_sel, bus_p.shift_sel, bus_p.acc_load,
                bus_p.acc_en, bus_p.busy, bus_p.done, bus_p.state_out};

  function automatic logic [15:0] partial(input logic [7:0] a, input logic [7:0] b,
                                          input logic as, input logic bs,
                                          input logic [1:0] sh);
    logic [15:0] na, nb;
    na = as ? {12'd0, a[7:4]} : {12'd0, a[3:0]};
    nb = bs ? {12'd0, b[7:4]} : {12'd0, b[3:0]};
    return (na * nb) << (4 * sh);
  endfunction

  logic [15:0] acc_h, acc_p;
  always @(posedge clk) begin
    if (bus_h.acc_load)
      acc_h <= partial(a_op, b_op, bus_h.a_sel, bus_h.b_sel, bus_h.shift_sel);
    else if (bus_h.acc_en)
      acc_h <= acc_h + partial(a_op, b_op, bus_h.a_sel, bus_h.b_sel, bus_h.shift_sel);
    if (bus_p.acc_load)
      acc_p <= partial(a_op, b_op, bus_p.a_sel, bus_p.b_sel, bus_p.shift_sel);
    else if (bus_p.acc_en)
      acc_p <= acc_p + partial(a_op, b_op, bus_p.a_sel, bus_p.b_sel, bus_p.shift_sel);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: compare on the first cycle done is seen.
  logic pd_h = 1'b0, pd_p = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      pd_h = 1'b0;
    end else begin
      if (bus_h.done && !pd_h) begin
        if (q_h.size() == 0) chk("hold unexpected done", 1, 0);
        else begin
          e_h = q_h.pop_front();
          chk("hold done cycle", cyc, e_h.cyc);
          chk("hold product", {16'd0, acc_h}, e_h.prod);
        end
      end
      pd_h = bus_h.done;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      pd_p = 1'b0;
    end else begin
      if (pd_p) chk("pulse done width", {31'd0, bus_p.done}, 0);
      if (bus_p.done && !pd_p) begin
        if (q_p.size() == 0) chk("pulse unexpected done", 1, 0);
        else begin
          e_p = q_p.pop_front();
          chk("pulse done cycle", cyc, e_p.cyc);
          chk("pulse product", {16'd0, acc_p}, e_p.prod);
        end
      end
      pd_p = bus_p.done;
    end
  end

  // Called #1 after a rising edge; start is sampled at the next edge (k).
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit expect_done);
    exp_t e;
    a_op  = a;
    b_op  = b;
    start = 1'b1;
    e.cyc  = cyc + 1 + 4;
    e.prod = int'(a) * int'(b);
    if (expect_done) begin
      q_h.push_back(e);
      q_p.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((bus_h.state_out == 3'b000 || bus_h.state_out == 3'b010) &&
          (bus_p.state_out == 3'b000 || bus_p.state_out == 3'b010)) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("ready timeout", 0, 1);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] calc_seq [4];
    logic [7:0]  ra, rb;
    calc_seq[0] = O_C0; calc_seq[1] = O_C1; calc_seq[2] = O_C2; calc_seq[3] = O_C3;
    reset = 1'b1;
    start = 1'b0;
    a_op  = '0;
    b_op  = '0;
    repeat (3) step();
    chk("reset outs hold", {21'd0, o_h}, {21'd0, O_IDLE});
    chk("reset outs pulse", {21'd0, o_p}, {21'd0, O_IDLE});
    reset = 1'b0;
    step();

    // FF*FF with per-cycle control sequence
    issue(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq cnt%0d hold", i), {21'd0, o_h}, {21'd0, calc_seq[i]});
      chk($sformatf("seq cnt%0d pulse", i), {21'd0, o_p}, {21'd0, calc_seq[i]});
      step();
    end
    chk("done outs hold", {21'd0, o_h}, {21'd0, O_DONE});
    chk("done outs pulse", {21'd0, o_p}, {21'd0, O_DONE});
    chk("acc FF*FF", {16'd0, acc_h}, 32'h0000FE01);
    step();
    chk("held done", {21'd0, o_h}, {21'd0, O_DONE});
    chk("pulse back to idle", {21'd0, o_p}, {21'd0, O_IDLE});
    step();
    chk("held done 2", {21'd0, o_h}, {21'd0, O_DONE});

    // Back-to-back: second start driven while in DONE
    issue(8'd0, 8'd200, 1'b1);
    wait_ready();
    issue(8'd13, 8'd11, 1'b1);
    wait_ready();
    step();

    // Start at cnt0 (held) and again at cnt2
    wait_ready();
`ifdef MULT_CTRL_ERR_EN
    issue(8'd7, 8'd9, 1'b0);
`else
    issue(8'd7, 8'd9, 1'b1);
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef MULT_CTRL_ERR_EN
    chk("err outs hold", {21'd0, o_h}, {21'd0, O_ERR});
    chk("err outs pulse", {21'd0, o_p}, {21'd0, O_ERR});
    step();
    chk("err exit hold", {21'd0, o_h}, {21'd0, O_IDLE});
    chk("err exit pulse", {21'd0, o_p}, {21'd0, O_IDLE});
`else
    chk("no err cnt3 hold", {21'd0, o_h}, {21'd0, O_C3});
    chk("no err cnt3 pulse", {21'd0, o_p}, {21'd0, O_C3});
    step();
`endif
    wait_ready();
    step();

    // Reset during cnt2: no done may follow
    issue(8'd21, 8'd33, 1'b0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("mid reset hold", {21'd0, o_h}, {21'd0, O_IDLE});
    chk("mid reset pulse", {21'd0, o_p}, {21'd0, O_IDLE});
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no done after reset", {30'd0, bus_h.done, bus_p.done}, 0);
    end

    // Randomised operands and gaps
    for (int unsigned n = 0; n < 24; n++) begin
      wait_ready();
      repeat ($urandom_range(0, 2)) step();
      case ($urandom_range(0, 5))
        0:       ra = 8'h00;
        1:       ra = 8'hFF;
        default: ra = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 8'h00;
        1:       rb = 8'hFF;
        default: rb = 8'($urandom);
      endcase
      issue(ra, rb, 1'b1);
    end
    wait_ready();
    repeat (3) step();
    chk("hold queue drained", q_h.size(), 0);
    chk("pulse queue drained", q_p.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_8x8_ctrl.md
# mult_8x8_ctrl

Control state machine for the sequential 8x8 multiplier. It runs the shared 4x4 multiplier over four cycles by selecting operand nibbles, the product shift amount, and the accumulator load/add enables, then flags completion. It also drives a 3-bit state code into the on-board seven-segment decoder, which shows 0/1/2 for idle/compute/done and "E" for the error state.

## Interface
- HOLD_DONE, 1, 1: DONE state and `done` persist until the next `start`; 0: `done` is a single-cycle pulse and the FSM returns to IDLE.
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level-sampled request to begin a multiply; operands must be stable at the datapath from the cycle `start` is sampled until `done`.
- a_sel  output  1  operand A nibble select: 0 = A[3:0], 1 = A[7:4].
- b_sel  output  1  operand B nibble select: 0 = B[3:0], 1 = B[7:4].
- shift_sel  output  2  product shift: 0 = <<0, 1 = <<4, 2 = <<8; 3 is never driven.
- acc_load  output  1  accumulator loads the shifted product (overwrites).
- acc_en  output  1  accumulator adds the shifted product.
- busy  output  1  high in CALC.
- done  output  1  result valid in accumulator.
- state_out  output  3  code for the seven-segment decoder.

## Operation
- States: IDLE, CALC (with 2-bit counter cnt 0..3), DONE, ERR. Moore outputs, decoded from the registered state and cnt only.
- IDLE: every output 0 and state_out=3'b000. If start=1, go to CALC with cnt=0.
- CALC (busy=1, state_out=3'b001):
  - cnt0: a_sel=0, b_sel=0, shift_sel=0, acc_load=1, acc_en=0.
  - cnt1: a_sel=0, b_sel=1, shift_sel=1, acc_load=0, acc_en=1.
  - cnt2: a_sel=1, b_sel=0, shift_sel=1, acc_en=1.
  - cnt3: a_sel=1, b_sel=1, shift_sel=2, acc_en=1.
  - cnt increments each cycle. After cnt3, go to DONE and reset cnt to 0.
  - `start` is ignored while in CALC, except as described under Configuration.
- DONE (done=1, state_out=3'b010; selects 0, acc_load/acc_en 0):
  - start=1 takes priority: go to CALC with cnt=0.
  - Otherwise, HOLD_DONE=1: remain in DONE. HOLD_DONE=0: go to IDLE.
- ERR (state_out=3'b111; decoder shows E; every other output 0):
  - start=0 → IDLE; start=1 → remain in ERR.
- Reset: state IDLE, cnt 0. Every output 0, state_out=3'b000.
- Arithmetic contract (datapath side): accumulator ≥16 bits, with final value A*B. The four partial products, each ≤225 shifted, sum without overflow to at most 65025.

## Timing
- `start` sampled high at edge k gives CALC cnt0..cnt3 in cycles k+1..k+4, and done=1 in cycle k+5. Latency is 5 cycles from the start edge to done.
- Back-to-back: with start held high in DONE, the next CALC begins one cycle after DONE, giving 5 cycles per multiply.
- reset has priority over every transition. Asserting it during CALC gives IDLE on the next edge with acc_en/acc_load=0. The accumulator contents are then undefined to the consumer, and done stays 0.
- state_out changes on the same edge as the state. There is no extra register stage toward the decoder.

## Configuration
- MULT_CTRL_ERR_EN defined: start=1 sampled while in CALC at cnt1..cnt3 aborts to ERR on the next edge. At cnt0, start is treated as the still-held original request and ignored.
- MULT_CTRL_ERR_EN undefined:
  - ERR is not implemented, and `start` is ignored throughout CALC.
  - state_out never takes the value 3'b111.

## Test plan
- Reset, then A=8'hFF, B=8'hFF, one-cycle start: the bench sees the select/shift sequence (0,0,0)(0,1,1)(1,0,1)(1,1,2) in cycles k+1..k+4. At k+5, done=1, state_out=2, and the model accumulator is 16'hFE01.
- A=8'd0, B=8'd200, then A=8'd13, B=8'd11, with start held high across DONE: result 0, then result 143, each done exactly 5 cycles after its start edge.
- HOLD_DONE=0: start pulse → done high for exactly 1 cycle, then state_out=0 and IDLE.
- With MULT_CTRL_ERR_EN: start pulses at cnt0 and again at cnt2 → ERR one cycle later with state_out=3'b111. With start then held low one cycle → IDLE. Without the macro, the same stimulus completes normally with done at k+5.
- reset asserted at cnt2 → next cycle IDLE, every output 0, busy=0, and no done is produced.
